// File: rtl/ram_pkg.sv
// ram_pkg: shared constants for the matrix register file.
//   DEF_DATA_W / DEF_ADDR_W : default data and address widths
//   A_BASE / B_BASE / C_BASE : first address of each matrix
//   ADDR_A00 .. ADDR_C11     : address of every individual register
//   NUM_REGS                 : total number of registers (29)
package ram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;

    localparam int A_BASE   = 0;
    localparam int B_BASE   = 16;
    localparam int C_BASE   = 25;
    localparam int NUM_REGS = 29;

    // Matrix A, 4x4, row-major
    localparam int ADDR_A00 = A_BASE + 0;
    localparam int ADDR_A01 = A_BASE + 1;
    localparam int ADDR_A02 = A_BASE + 2;
    localparam int ADDR_A03 = A_BASE + 3;
    localparam int ADDR_A10 = A_BASE + 4;
    localparam int ADDR_A11 = A_BASE + 5;
    localparam int ADDR_A12 = A_BASE + 6;
    localparam int ADDR_A13 = A_BASE + 7;
    localparam int ADDR_A20 = A_BASE + 8;
    localparam int ADDR_A21 = A_BASE + 9;
    localparam int ADDR_A22 = A_BASE + 10;
    localparam int ADDR_A23 = A_BASE + 11;
    localparam int ADDR_A30 = A_BASE + 12;
    localparam int ADDR_A31 = A_BASE + 13;
    localparam int ADDR_A32 = A_BASE + 14;
    localparam int ADDR_A33 = A_BASE + 15;

    // Matrix B, 3x3, row-major
    localparam int ADDR_B00 = B_BASE + 0;
    localparam int ADDR_B01 = B_BASE + 1;
    localparam int ADDR_B02 = B_BASE + 2;
    localparam int ADDR_B10 = B_BASE + 3;
    localparam int ADDR_B11 = B_BASE + 4;
    localparam int ADDR_B12 = B_BASE + 5;
    localparam int ADDR_B20 = B_BASE + 6;
    localparam int ADDR_B21 = B_BASE + 7;
    localparam int ADDR_B22 = B_BASE + 8;

    // Matrix C, 2x2, row-major
    localparam int ADDR_C00 = C_BASE + 0;
    localparam int ADDR_C01 = C_BASE + 1;
    localparam int ADDR_C10 = C_BASE + 2;
    localparam int ADDR_C11 = C_BASE + 3;

endpackage

// File: rtl/ram_cell.sv
// ram_cell: one DATA_W-bit storage register.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low clear
//   load : capture d on the next rising edge
//   d    : write data
//   q    : stored value
module ram_cell
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram.sv
// ram: write-only register file exposing three matrices as parallel outputs.
//   clk, rst    : clock and asynchronous active-low reset
//   en          : write enable
//   addr        : write address (0..15 A, 16..24 B, 25..28 C, 29..31 ignored)
//   in          : write data
//   a00..a33    : 4x4 matrix A
//   b00..b22    : 3x3 matrix B
//   c00..c11    : 2x2 matrix C
module ram
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] a00, a01, a02, a03,
    output logic [DATA_W-1:0] a10, a11, a12, a13,
    output logic [DATA_W-1:0] a20, a21, a22, a23,
    output logic [DATA_W-1:0] a30, a31, a32, a33,
    output logic [DATA_W-1:0] b00, b01, b02,
    output logic [DATA_W-1:0] b10, b11, b12,
    output logic [DATA_W-1:0] b20, b21, b22,
    output logic [DATA_W-1:0] c00, c01,
    output logic [DATA_W-1:0] c10, c11
);

    logic [NUM_REGS-1:0] load;
    logic [DATA_W-1:0]   q [NUM_REGS];

    // One-hot load strobes; addresses past the last register match nothing.
    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            load[i] = en && (addr == ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        ram_cell #(.DATA_W(DATA_W)) u_cell (
            .clk  (clk),
            .rst  (rst),
            .load (load[g]),
            .d    (in),
            .q    (q[g])
        );
    end

    assign a00 = q[ADDR_A00];
    assign a01 = q[ADDR_A01];
    assign a02 = q[ADDR_A02];
    assign a03 = q[ADDR_A03];
    assign a10 = q[ADDR_A10];
    assign a11 = q[ADDR_A11];
    assign a12 = q[ADDR_A12];
    assign a13 = q[ADDR_A13];
    assign a20 = q[ADDR_A20];
    assign a21 = q[ADDR_A21];
    assign a22 = q[ADDR_A22];
    assign a23 = q[ADDR_A23];
    assign a30 = q[ADDR_A30];
    assign a31 = q[ADDR_A31];
    assign a32 = q[ADDR_A32];
    assign a33 = q[ADDR_A33];
    assign b00 = q[ADDR_B00];
    assign b01 = q[ADDR_B01];
    assign b02 = q[ADDR_B02];
    assign b10 = q[ADDR_B10];
    assign b11 = q[ADDR_B11];
    assign b12 = q[ADDR_B12];
    assign b20 = q[ADDR_B20];
    assign b21 = q[ADDR_B21];
    assign b22 = q[ADDR_B22];
    assign c00 = q[ADDR_C00];
    assign c01 = q[ADDR_C01];
    assign c10 = q[ADDR_C10];
    assign c11 = q[ADDR_C11];

endmodule

// File: tb/tb_ram.sv
// tb_ram: self-checking bench for the ram matrix register file.
module tb_ram;

    localparam int NR = 29;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] addr;
    logic [7:0] din;

    logic [7:0] a00, a01, a02, a03, a10, a11, a12, a13;
    logic [7:0] a20, a21, a22, a23, a30, a31, a32, a33;
    logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;
    logic [7:0] c00, c01, c10, c11;

    ram #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .en(en), .addr(addr), .in(din),
        .a00(a00), .a01(a01), .a02(a02), .a03(a03),
        .a10(a10), .a11(a11), .a12(a12), .a13(a13),
        .a20(a20), .a21(a21), .a22(a22), .a23(a23),
        .a30(a30), .a31(a31), .a32(a32), .a33(a33),
        .b00(b00), .b01(b01), .b02(b02),
        .b10(b10), .b11(b11), .b12(b12),
        .b20(b20), .b21(b21), .b22(b22),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11)
    );

    always #5 clk = ~clk;

    // Outputs gathered in address order.
    logic [7:0] cur [NR];
    assign cur[0]  = a00; assign cur[1]  = a01; assign cur[2]  = a02; assign cur[3]  = a03;
    assign cur[4]  = a10; assign cur[5]  = a11; assign cur[6]  = a12; assign cur[7]  = a13;
    assign cur[8]  = a20; assign cur[9]  = a21; assign cur[10] = a22; assign cur[11] = a23;
    assign cur[12] = a30; assign cur[13] = a31; assign cur[14] = a32; assign cur[15] = a33;
    assign cur[16] = b00; assign cur[17] = b01; assign cur[18] = b02;
    assign cur[19] = b10; assign cur[20] = b11; assign cur[21] = b12;
    assign cur[22] = b20; assign cur[23] = b21; assign cur[24] = b22;
    assign cur[25] = c00; assign cur[26] = c01; assign cur[27] = c10; assign cur[28] = c11;

    int errors = 0;
    int checks = 0;

    logic [7:0]        mdl [NR];
    logic [NR*8-1:0]   sb [$];

    typedef struct {
        logic       en;
        logic [4:0] addr;
        logic [7:0] din;
        int         chk_idx;
        logic [7:0] chk_val;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [NR*8-1:0] pack_mdl();
        logic [NR*8-1:0] p;
        for (int i = 0; i < NR; i++) p[i*8 +: 8] = mdl[i];
        return p;
    endfunction

    task automatic check_one(input string tag, input int idx, input logic [7:0] req);
        checks++;
        if (cur[idx] !== req) begin
            errors++;
            $display("FAIL %s reg%0d actual=%h required=%h", tag, idx, cur[idx], req);
        end
    endtask

    task automatic check_vec(input string tag, input logic [NR*8-1:0] exp_v);
        for (int i = 0; i < NR; i++) check_one(tag, i, exp_v[i*8 +: 8]);
    endtask

    task automatic clear_mdl();
        for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    endtask

    // Drive one cycle of stimulus (called just after a falling edge); the
    // expected image is queued now and compared one rising edge later.
    task automatic step(input string tag, input logic e, input logic [4:0] a, input logic [7:0] d);
        logic [NR*8-1:0] exp_v;
        en = e; addr = a; din = d;
        if (e && a < 5'(NR)) mdl[a] = d;
        sb.push_back(pack_mdl());
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            exp_v = sb.pop_front();
            check_vec(tag, exp_v);
        end
    endtask

    initial begin
        // Fill pattern: addr k gets k
        for (int k = 0; k < 25; k++) vecs.push_back('{1'b1, 5'(k), 8'(k), k, 8'(k)});
        // en low: a11 keeps 5 whatever addr/in say
        for (int k = 0; k < 3; k++) vecs.push_back('{1'b0, 5'd5, 8'hAA, 5, 8'h05});
        vecs.push_back('{1'b1, 5'd5, 8'hAA, 5, 8'hAA});
        // Matrix C then ignored addresses
        vecs.push_back('{1'b1, 5'd25, 8'hF0, 25, 8'hF0});
        vecs.push_back('{1'b1, 5'd26, 8'hF1, 26, 8'hF1});
        vecs.push_back('{1'b1, 5'd27, 8'hF2, 27, 8'hF2});
        vecs.push_back('{1'b1, 5'd28, 8'hF3, 28, 8'hF3});
        vecs.push_back('{1'b1, 5'd29, 8'hFF, 28, 8'hF3});
        vecs.push_back('{1'b1, 5'd30, 8'hFF, 0,  8'h00});
        vecs.push_back('{1'b1, 5'd31, 8'hFF, 24, 8'h18});
        // Back-to-back writes to one address keep the last value
        vecs.push_back('{1'b1, 5'd3, 8'h11, 3, 8'h11});
        vecs.push_back('{1'b1, 5'd3, 8'h22, 3, 8'h22});

        // Reset with garbage inputs: outputs clear without any clock edge
        clear_mdl();
        rst = 1'b0; en = 1'b1; addr = 5'd7; din = 8'h5A;
        #1;
        check_vec("reset_async", pack_mdl());
        repeat (2) begin
            @(posedge clk);
            addr = 5'($urandom_range(0, 31)); din = 8'($urandom);
            @(negedge clk);
        end
        check_vec("reset_held", pack_mdl());
        rst = 1'b1; en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_vec("reset_after", pack_mdl());

        // Table-driven vectors
        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].din);
            check_one($sformatf("vec%0d_target", i), vecs[i].chk_idx, vecs[i].chk_val);
        end

        // Refill A and B, then reset between edges
        for (int k = 0; k < 25; k++) step("refill", 1'b1, 5'(k), 8'(k));
        en = 1'b0;
        #2;
        rst = 1'b0;
        clear_mdl();
        #1;
        check_vec("midreset_async", pack_mdl());

        // A write presented while reset is low is lost
        en = 1'b1; addr = 5'd3; din = 8'h77;
        @(posedge clk);
        @(negedge clk);
        check_vec("reset_edge_write", pack_mdl());
        rst = 1'b1; en = 1'b0;

        step("post_reset_b22", 1'b1, 5'd24, 8'h55);
        check_one("post_reset_b22_target", 24, 8'h55);
        step("idle", 1'b0, 5'd24, 8'h00);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
